// File: rtl/imem_pkg.sv
// Shared constants and pipeline stage type for the instruction-memory fetch port.
package imem_pkg;

    localparam int          IMEM_MAX_DATA_W = 64;
    localparam logic [31:0] NOP             = 32'h0000_0000;
    localparam int          LATENCY_MIN     = 1;
    localparam int          LATENCY_MAX     = 4;

    // instr is sized for the widest supported word; narrower words sit in the low bits
    typedef struct packed {
        logic                       valid;
        logic [IMEM_MAX_DATA_W-1:0] instr;
        logic                       fault;
    } stage_t;

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch, response, flush and program-load signals between the fetch stage and the instruction memory.
interface imem_fetch_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: one synchronous read port, one synchronous write port, read-before-write.
module imem_array #(
    parameter int DEPTH  = 65536,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset so a loaded program outlives a core reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port, flushable read pipeline and runtime load port.
// Define IMEM_FAULT_CHECK_EN to flag misaligned / out-of-range fetches and drop such loads.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int LATENCY   = 1,
    parameter int BYTE_ADDR = 1
) (
    input logic               clk,
    input logic               rst,
    imem_fetch_port_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF   = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
    localparam int LAT   = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

    logic              stall;
    logic              accept;
    logic              req_fault;
    logic              load_fault;
    logic              wr_en;
    logic              s0_valid;
    logic              s0_fault;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] rd_data;
    stage_t            s0;
    stage_t            last;

`ifdef IMEM_FAULT_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFF) - 1);

    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        return ((a & LOW_MASK) != '0) || ((a >> OFF) >= ADDR_W'(DEPTH));
    endfunction

    assign req_fault  = addr_fault(bus.req_addr);
    assign load_fault = addr_fault(bus.load_addr);
`else
    assign req_fault  = 1'b0;
    assign load_fault = 1'b0;
`endif

    assign stall         = last.valid && !bus.rsp_ready;
    assign bus.req_ready = !bus.load_en && !stall;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_idx        = IDX_W'(bus.req_addr >> OFF);
    assign wr_idx        = IDX_W'(bus.load_addr >> OFF);
    assign wr_en         = bus.load_en && !rst && !load_fault;

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (accept),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (bus.load_data)
    );

    // Stage 0 control: the fault flag only moves with an accepted read so it stays paired with rd_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_fault <= 1'b0;
        end else begin
            if (!stall) begin
                s0_valid <= accept;
            end else if (flush_in()) begin
                s0_valid <= 1'b0;
            end
            if (accept) begin
                s0_fault <= req_fault;
            end
        end
    end

    function automatic logic flush_in();
        return bus.flush;
    endfunction

    always_comb begin
        s0       = '0;
        s0.valid = s0_valid;
        s0.fault = s0_fault;
        s0.instr = s0_fault ? IMEM_MAX_DATA_W'(NOP) : IMEM_MAX_DATA_W'(rd_data);
    end

    generate
        if (LAT == 1) begin : g_single
            assign last = s0;
        end else begin : g_multi
            stage_t tail [LAT-1];

            // Shift while decode takes data; a flush kills every valid even when frozen
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        tail[k] <= '0;
                    end
                end else begin
                    if (!stall) begin
                        tail[0] <= s0;
                        for (int k = 1; k < LAT - 1; k++) begin
                            tail[k] <= tail[k-1];
                        end
                    end
                    if (bus.flush) begin
                        for (int k = 0; k < LAT - 1; k++) begin
                            tail[k].valid <= 1'b0;
                        end
                    end
                end
            end

            assign last = tail[LAT-2];
        end
    endgenerate

    assign bus.rsp_valid = last.valid;
    assign bus.rsp_instr = last.instr[DATA_W-1:0];
    assign bus.rsp_fault = last.fault;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed self-checking bench for imem_fetch_port (LATENCY=3, DEPTH=16, byte addressing).
// Expectations follow IMEM_FAULT_CHECK_EN when it is defined for the build.
module tb_imem_fetch_port;

    localparam logic [31:0] W0   = 32'h2001_0005;
    localparam logic [31:0] W1   = 32'h0000_0000;
    localparam logic [31:0] W2   = 32'h1111_1111;
    localparam logic [31:0] W3   = 32'h3333_3333;
    localparam logic [31:0] W15  = 32'h5A5A_5A5A;
    localparam logic [31:0] WNEW = 32'hCAFE_F00D;
    localparam logic [31:0] W8B  = 32'h0BAD_C0DE;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    imem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_fetch_port #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (16),
        .LATENCY   (3),
        .BYTE_ADDR (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic expectRsp(input string tag, input logic valid, input logic [31:0] instr);
        checkOutput({tag, ".valid"}, 32'(bus.rsp_valid), 32'(valid));
        if (valid) begin
            checkOutput({tag, ".instr"}, bus.rsp_instr, instr);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic ready);
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.rsp_ready = ready;
        tick();
    endtask

    task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        repeat (2) tick();
        checkOutput("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset.rsp_instr", bus.rsp_instr, 32'd0);
        checkOutput("reset.rsp_fault", 32'(bus.rsp_fault), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset.req_ready", 32'(bus.req_ready), 32'd1);

        loadWord(32'h00, W0);
        loadWord(32'h04, W1);
        loadWord(32'h08, W2);
        loadWord(32'h0C, W3);
        loadWord(32'h3C, W15);

        // Two fetches, responses LATENCY cycles after each accept
        applyStimulus(1'b1, 32'h0, 1'b1); expectRsp("basic.e1", 1'b0, '0);
        applyStimulus(1'b1, 32'h4, 1'b1); expectRsp("basic.e2", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("basic.r0", 1'b1, W0);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("basic.r1", 1'b1, W1);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("basic.idle", 1'b0, '0);

        // Back-to-back stream with a two-cycle decode stall
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h4, 1'b1);
        applyStimulus(1'b1, 32'h8, 1'b1); expectRsp("stream.r0", 1'b1, W0);
        applyStimulus(1'b1, 32'hC, 1'b0); expectRsp("stream.stall1", 1'b1, W0);
        checkOutput("stream.stall1.req_ready", 32'(bus.req_ready), 32'd0);
        applyStimulus(1'b1, 32'hC, 1'b0); expectRsp("stream.stall2", 1'b1, W0);
        checkOutput("stream.stall2.req_ready", 32'(bus.req_ready), 32'd0);
        applyStimulus(1'b1, 32'hC, 1'b1); expectRsp("stream.r1", 1'b1, W1);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("stream.r2", 1'b1, W2);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("stream.r3", 1'b1, W3);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("stream.idle", 1'b0, '0);

        // Flush with the redirect accepted on the same edge
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h4, 1'b1);
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'h3C, 1'b1); expectRsp("flush.edge", 1'b0, '0);
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("flush.gap", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("flush.target", 1'b1, W15);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("flush.idle", 1'b0, '0);

        // Flush while stalled with three fetches in flight
        applyStimulus(1'b1, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h4, 1'b0);
        applyStimulus(1'b1, 32'h8, 1'b0); expectRsp("flush2.full", 1'b1, W0);
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'h3C, 1'b0); expectRsp("flush2.killed", 1'b0, '0);
        bus.flush = 1'b0;
        applyStimulus(1'b1, 32'h3C, 1'b1); expectRsp("flush2.e1", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1);  expectRsp("flush2.e2", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1);  expectRsp("flush2.target", 1'b1, W15);
        applyStimulus(1'b0, 32'h0, 1'b1);  expectRsp("flush2.idle", 1'b0, '0);

        // Load with a fetch pending: fetch waits, then sees the new word
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h8;
        bus.load_data = WNEW;
        #1;
        checkOutput("load.req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.load_en = 1'b0;
        #1;
        checkOutput("load.req_ready_after", 32'(bus.req_ready), 32'd1);
        applyStimulus(1'b1, 32'h8, 1'b1); expectRsp("load.e1", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("load.e2", 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("load.new", 1'b1, WNEW);

        // A fetch already read keeps the old word while a load to it drains past
        applyStimulus(1'b1, 32'h8, 1'b1);
        bus.req_valid = 1'b0;
        loadWord(32'h8, W8B);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("drain.old", 1'b1, WNEW);
        applyStimulus(1'b1, 32'h8, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("drain.new", 1'b1, W8B);

        // Misaligned and out-of-range addresses
        applyStimulus(1'b1, 32'h2, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef IMEM_FAULT_CHECK_EN
        expectRsp("fault.misaligned", 1'b1, 32'h0);
        checkOutput("fault.misaligned.flag", 32'(bus.rsp_fault), 32'd1);
`else
        expectRsp("fault.misaligned", 1'b1, W0);
        checkOutput("fault.misaligned.flag", 32'(bus.rsp_fault), 32'd0);
`endif
        applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef IMEM_FAULT_CHECK_EN
        expectRsp("fault.range", 1'b1, 32'h0);
        checkOutput("fault.range.flag", 32'(bus.rsp_fault), 32'd1);
`else
        expectRsp("fault.range", 1'b1, W0);
        checkOutput("fault.range.flag", 32'(bus.rsp_fault), 32'd0);
`endif
        loadWord(32'h44, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h4, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef IMEM_FAULT_CHECK_EN
        expectRsp("fault.load_dropped", 1'b1, W1);
`else
        expectRsp("fault.load_wraps", 1'b1, 32'hDEAD_BEEF);
`endif

        // Reset with fetches in flight; a load on the reset edge must not land
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h4, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("rstmid.before", 1'b1, W0);
        rst           = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h0;
        bus.load_data = 32'hFFFF_FFFF;
        #1;
        checkOutput("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstmid.rsp_instr", bus.rsp_instr, 32'd0);
        tick();
        bus.load_en = 1'b0;
        rst         = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("rstmid.after", 1'b0, '0);
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1); expectRsp("rstmid.mem_intact", 1'b1, W0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
